data_mem: RTL

//   Data memory stage directly downstream of the ALU: the ALU result AO is the

---
 rtl/data_mem.sv | 127 ++++++++++++
 1 files changed

// File: rtl/data_mem.sv
// Word-organised data memory behind the ALU: sub-word stores, sign/zero-extended loads,
// and combinational address-error flags for the controller.
module data_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic [1:0]  StoreOp,
  input  logic        MemRead,
  input  logic [2:0]  LoadOp,
  output logic [31:0] RD,
  output logic        AdEL,
  output logic        AdES
);

  typedef enum logic [1:0] {
    ST_W   = 2'd0,
    ST_H   = 2'd1,
    ST_B   = 2'd2,
    ST_RSV = 2'd3
  } store_op_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_H  = 3'd1,
    LD_HU = 3'd2,
    LD_B  = 3'd3,
    LD_BU = 3'd4
  } load_op_e;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [15:0]   half;
  logic [7:0]    byte_sel;
  logic          oor;
  logic          armed;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic [31:0]   merged;

  assign idx  = Addr[AW+1:2];
  assign word = mem[idx];
  assign oor  = |Addr[31:AW+2];

  assign AdES = MemWrite & (oor | ((StoreOp == ST_W) & (Addr[1:0] != 2'b00))
                                | ((StoreOp == ST_H) & Addr[0]));
  assign AdEL = MemRead  & (oor | ((LoadOp == LD_W) & (Addr[1:0] != 2'b00))
                                | (((LoadOp == LD_H) | (LoadOp == LD_HU)) & Addr[0]));

  always_comb begin
    half     = Addr[1] ? word[31:16] : word[15:0];
    byte_sel = '0;
    case (Addr[1:0])
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    RD = '0;
    case (LoadOp)
      LD_W:    RD = word;
      LD_H:    RD = {{16{half[15]}}, half};
      LD_HU:   RD = {16'h0000, half};
      LD_B:    RD = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   RD = {24'h000000, byte_sel};
      default: RD = '0;
    endcase
  end

  always_comb begin
    be   = '0;
    wdat = '0;
    case (StoreOp)
      ST_W: begin
        be   = 4'b1111;
        wdat = WD;
      end
      ST_H: begin
        be   = Addr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{WD[15:0]}};
      end
      ST_B: begin
        be   = 4'b0001 << Addr[1:0];
        wdat = {4{WD[7:0]}};
      end
      default: begin
        be   = '0;
        wdat = '0;
      end
    endcase
    merged = word;
    for (int unsigned l = 0; l < 4; l++) begin
      if (be[l]) merged[8*l +: 8] = wdat[8*l +: 8];
    end
  end

  // Arms on the falling edge after reset release, so the rising edge that
  // coincides with release can never commit a store.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  assign we = armed & MemWrite & ~AdES & (StoreOp != ST_RSV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= merged;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && we) $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, merged);
  end
`endif

endmodule
